// File: rtl/unary_decoder.sv
// Thermometer (MSB-first unary) to binary decoder, two-stage valid/ready pipe; optional THERM_CHECK_EN builds malformed-word detection.
// Latency: 2 cycles from accepted input to out_valid; one word per cycle sustained.
// Backpressure: out_ready=0 stalls S2, then S1; in_ready drops once both stages hold a word.
module unary_decoder #(
  parameter int N     = 16,
  parameter int OUT_W = $clog2(N),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     unary_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] bin_out,
  output logic             err_out,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam int                PC_W    = $clog2(N + 1);
  localparam logic [PC_W-1:0]   PC_MAX  = PC_W'(N - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [PC_W-1:0]  pop;
  logic [OUT_W-1:0] bin_d;
  logic             bad_d;

  logic             s1_valid;
  logic [OUT_W-1:0] s1_bin;
  logic             s1_err;
  logic             s2_valid;
  logic [OUT_W-1:0] s2_bin;
  logic             s2_err;

  logic             s2_adv;
  logic             in_fire;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + PC_W'(unary_in[i]);
    end
  end

  // The all-ones word counts to N, which does not fit OUT_W bits.
  assign bin_d = (pop > PC_MAX) ? PC_MAX[OUT_W-1:0] : pop[OUT_W-1:0];

`ifdef THERM_CHECK_EN
  logic gap;

  always_comb begin
    gap = 1'b0;
    for (int i = 1; i < N; i++) begin
      if (!unary_in[i] && unary_in[i-1]) begin
        gap = 1'b1;
      end
    end
  end

  assign bad_d = gap || (&unary_in);
`else
  assign bad_d = 1'b0;
`endif

  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s1_err   <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_bin   <= bin_d;
      s1_err   <= bad_d;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Data only moves with a valid word, so bin_out keeps its last value when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_bin   <= '0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bin <= s1_bin;
        s2_err <= s1_err;
      end
    end
  end

  assign out_valid = s2_valid;
  assign bin_out   = s2_bin;
  assign err_out   = s2_valid && s2_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && err_out && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

`ifndef SYNTHESIS
  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(bin_out)));

  a_clr_zero: assert property (@(posedge clk) disable iff (rst)
    err_clr |=> (err_cnt == '0));
`endif

endmodule

// File: tb/tb_unary_decoder.sv
// Directed bench for unary_decoder; expectations follow THERM_CHECK_EN when it is defined for the build.
module tb_unary_decoder;

  localparam int N     = 16;
  localparam int OUT_W = 4;
  localparam int CNT_W = 16;

`ifdef THERM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     unary_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] bin_out;
  logic             err_out;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr;

  int n_chk = 0;
  int n_bad = 0;

  logic [N-1:0] ones;

  unary_decoder #(.N(N), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .unary_in  (unary_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err_out   (err_out),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Expected error-related value: real value with the checker built, zero otherwise.
  function automatic logic [31:0] ex(input int v);
    return CHK ? 32'(v) : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    unary_in  = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    ones      = '1;

    // Reset state
    step();
    step();
    chk("rst_vld", out_valid, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_cnt", err_cnt, 0);
    rst = 1'b0;
    step();
    chk("rst_rdy", in_ready, 1);

    // Stream codes 0..15 back-to-back
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        in_valid = 1'b1;
        unary_in = ~(ones >> c);
        chk("str_rdy", in_ready, 1);
      end else begin
        in_valid = 1'b0;
        unary_in = '0;
      end
      step();
      chk("str_vld", out_valid, (c >= 1 && c <= 16) ? 1 : 0);
      if (c >= 1 && c <= 16) chk("str_bin", bin_out, c - 1);
    end
    chk("str_cnt", err_cnt, 0);

    // Backpressure: fill both stages, hold, release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    unary_in  = 16'hF000;
    step();
    chk("bp_rdyA", in_ready, 1);
    chk("bp_vldA", out_valid, 0);
    unary_in = 16'hFC00;
    step();
    in_valid = 1'b0;
    unary_in = '0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_vld", out_valid, 1);
      chk("bp_bin", bin_out, 4);
      chk("bp_rdy", in_ready, 0);
      step();
    end
    chk("bp_hold", bin_out, 4);
    out_ready = 1'b1;
    step();
    chk("bp_vld2", out_valid, 1);
    chk("bp_bin2", bin_out, 6);
    step();
    chk("bp_empty", out_valid, 0);

    // Malformed words: gap and all-ones
    in_valid = 1'b1;
    unary_in = 16'hA000;
    step();
    unary_in = 16'hFFFF;
    step();
    in_valid = 1'b0;
    unary_in = '0;
    chk("bad_bin1", bin_out, 2);
    chk("bad_err1", err_out, ex(1));
    step();
    chk("bad_bin2", bin_out, 15);
    chk("bad_err2", err_out, ex(1));
    step();
    chk("bad_vld", out_valid, 0);
    chk("bad_cnt", err_cnt, ex(2));

    // Clear wins over simultaneous increment
    in_valid = 1'b1;
    unary_in = 16'h0001;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_bin", bin_out, 1);
    chk("clr_err", err_out, ex(1));
    step();
    chk("clr_cnt3", err_cnt, ex(3));
    in_valid = 1'b1;
    unary_in = 16'h4000;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_vld", out_valid, 1);
    chk("clr_err2", err_out, ex(1));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_cnt0", err_cnt, 0);
    step();
    chk("clr_stay", err_cnt, 0);

    // Reset with both stages full
    in_valid = 1'b1;
    unary_in = 16'hA000;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mrst_cnt1", err_cnt, ex(1));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    unary_in  = 16'h8000;
    step();
    unary_in = 16'hC000;
    step();
    in_valid = 1'b0;
    unary_in = '0;
    chk("mrst_full", out_valid, 1);
    chk("mrst_rdy0", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_cnt", err_cnt, 0);
    chk("mrst_rdy", in_ready, 1);
    step();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mrst_stale", out_valid, 0);
    end

    // Alternating pattern
    in_valid = 1'b1;
    unary_in = 16'h5555;
    step();
    in_valid = 1'b0;
    unary_in = '0;
    step();
    chk("alt_vld", out_valid, 1);
    chk("alt_bin", bin_out, 8);
    chk("alt_err", err_out, ex(1));
    step();
    chk("alt_cnt", err_cnt, ex(1));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
